// File: rtl/bpu_array_if.sv
// Command/result bus of the binary processing array: command strobe and operands in,
// handshaked signed channel results out.
interface bpu_array_if #(
    parameter int N_CH      = 8,
    parameter int BANK_ROWS = 8,
    parameter int ACC_W     = 12
);
    logic                    sel;
    logic                    cmd_valid;
    logic [2:0]              cmd;
    logic [BANK_ROWS-1:0]    data_in;
    logic                    bank_sel;
    logic                    col_sel;
    logic                    acc_keep;
    logic                    cmd_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_CH*ACC_W-1:0]   bpu_out;
    logic                    busy;

    modport master (
        output sel, cmd_valid, cmd, data_in, bank_sel, col_sel, acc_keep, out_ready,
        input  cmd_ready, out_valid, bpu_out, busy
    );

    modport slave (
        input  sel, cmd_valid, cmd, data_in, bank_sel, col_sel, acc_keep, out_ready,
        output cmd_ready, out_valid, bpu_out, busy
    );
endinterface

// File: rtl/bpu_array.sv
// Binary (XNOR/popcount) convolution array: N_CH channels of KxK bit kernels applied to a
// KxK window of a two-bank image store, producing saturated bipolar dot products.
module bpu_array #(
    parameter int N_CH      = 8,
    parameter int K         = 7,
    parameter int BANK_ROWS = 8,
    parameter int ACC_W     = 12
) (
    input  logic          clk,
    input  logic          rst,
    bpu_array_if.slave    bus
);
    localparam int N_W    = N_CH * K;
    localparam int N_ROWS = 2 * BANK_ROWS;
    localparam int SUM_W  = $clog2(K * K + 1);
    localparam int DOT_W  = SUM_W + 2;
    localparam int EXT_W  = ((ACC_W > DOT_W) ? ACC_W : DOT_W) + 1;
    localparam int RC_W   = (K > 1) ? $clog2(K) : 1;
    localparam int WI_W   = (N_W > 1) ? $clog2(N_W) : 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [EXT_W-1:0] KK      = EXT_W'(K * K);

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_WLOAD   = 3'd1,
        OP_ILOAD   = 3'd2,
        OP_ROWUP   = 3'd3,
        OP_COMPUTE = 3'd4,
        OP_CLEAR   = 3'd5
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    logic [K-1:0]             wmem [N_W];
    logic [K:0]               img  [N_ROWS];
    logic [K-1:0]             win  [K];
    logic [SUM_W-1:0]         sum     [N_CH];
    logic [SUM_W-1:0]         sum_nxt [N_CH];
    logic signed [ACC_W-1:0]  result     [N_CH];
    logic signed [ACC_W-1:0]  result_nxt [N_CH];

    state_e                   state;
    logic [RC_W-1:0]          row_cnt;
    logic                     keep_q;
    op_e                      op;
    logic                     accept;

    logic [WI_W-1:0]          widx;
    logic signed [EXT_W-1:0]  dot, prev, tot;

    assign op     = op_e'(bus.cmd);
    assign accept = bus.cmd_valid & bus.sel & bus.cmd_ready;

    function automatic logic [SUM_W-1:0] popcnt(input logic [K-1:0] v);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int b = 0; b < K; b++) n = n + SUM_W'(v[b]);
        return n;
    endfunction

    // Weight and image stores only change on an accepted load/shift command.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: these stores are flop arrays with a defined cleared state, so they are reset
            // explicitly; a RAM-style store would be left unreset instead.
            for (int i = 0; i < N_W; i++)    wmem[i] <= '0;
            for (int j = 0; j < N_ROWS; j++) img[j]  <= '0;
        end else if (accept) begin
            case (op)
                OP_WLOAD: begin
                    wmem[0] <= bus.data_in[K-1:0];
                    for (int i = 1; i < N_W; i++) wmem[i] <= wmem[i-1];
                end
                OP_ILOAD: begin
                    for (int i = 0; i < BANK_ROWS; i++) begin
                        if (bus.bank_sel)
                            img[BANK_ROWS+i] <= {img[BANK_ROWS+i][K-1:0], bus.data_in[i]};
                        else
                            img[i] <= {img[i][K-1:0], bus.data_in[i]};
                    end
                end
                OP_ROWUP: begin
                    for (int j = 0; j < N_ROWS - 1; j++) img[j] <= img[j+1];
                    img[N_ROWS-1] <= '0;
                end
                default: ;
            endcase
        end
    end

    // Per-channel partial sum for the current kernel row, and the final saturated result
    // that is committed on the last CALC cycle.
    always_comb begin
        // NOTE: combinational temporaries use blocking '=' so each later line sees the value
        // just computed; registers elsewhere use '<=' so all flops update together.
        widx = '0;
        dot  = '0;
        prev = '0;
        tot  = '0;
        for (int c = 0; c < N_CH; c++) begin
            widx       = WI_W'(c * K) + WI_W'(row_cnt);
            sum_nxt[c] = sum[c] + popcnt(~(win[row_cnt] ^ wmem[widx]));
            dot        = $signed({{(EXT_W-SUM_W-1){1'b0}}, sum_nxt[c], 1'b0}) - KK;
            prev       = '0;
            if (keep_q) prev = {{(EXT_W-ACC_W){result[c][ACC_W-1]}}, result[c]};
            tot = dot + prev;
            if (tot > SAT_MAX)      result_nxt[c] = SAT_MAX[ACC_W-1:0];
            else if (tot < SAT_MIN) result_nxt[c] = SAT_MIN[ACC_W-1:0];
            else                    result_nxt[c] = tot[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            row_cnt       <= '0;
            keep_q        <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                sum[c]    <= '0;
                result[c] <= '0;
            end
            for (int r = 0; r < K; r++) win[r] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && op == OP_COMPUTE) begin
                        state         <= S_CALC;
                        row_cnt       <= '0;
                        keep_q        <= bus.acc_keep;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        for (int c = 0; c < N_CH; c++) sum[c] <= '0;
                        for (int r = 0; r < K; r++)
                            win[r] <= bus.col_sel ? img[r][K:1] : img[r][K-1:0];
                    end else if (accept && op == OP_CLEAR) begin
                        for (int c = 0; c < N_CH; c++) result[c] <= '0;
                    end
                end
                S_CALC: begin
                    for (int c = 0; c < N_CH; c++) sum[c] <= sum_nxt[c];
                    if (row_cnt == RC_W'(K - 1)) begin
                        state         <= S_DONE;
                        bus.out_valid <= 1'b1;
                        for (int c = 0; c < N_CH; c++) result[c] <= result_nxt[c];
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state         <= S_IDLE;
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: the whole bus gets a default before the per-channel slices so no bit can
        // hold its old value and infer a latch.
        bus.bpu_out = '0;
        for (int c = 0; c < N_CH; c++) bus.bpu_out[c*ACC_W +: ACC_W] = result[c];
    end
endmodule

// File: tb/tb_bpu_array.sv
// Scoreboard bench for bpu_array: two instances (ACC_W=12 and ACC_W=7) driven in lockstep,
// checked against a queue/array reference model of the weight store, image store and results.
module tb_bpu_array;
    localparam int N_CH = 8;
    localparam int K    = 7;
    localparam int BR   = 8;
    localparam int AW   = 12;
    localparam int AW7  = 7;
    localparam int NW   = N_CH * K;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bpu_array_if #(.N_CH(N_CH), .BANK_ROWS(BR), .ACC_W(AW))  b12 ();
    bpu_array_if #(.N_CH(N_CH), .BANK_ROWS(BR), .ACC_W(AW7)) b7 ();

    bpu_array #(.N_CH(N_CH), .K(K), .BANK_ROWS(BR), .ACC_W(AW))  dut  (.clk(clk), .rst(rst), .bus(b12));
    bpu_array #(.N_CH(N_CH), .K(K), .BANK_ROWS(BR), .ACC_W(AW7)) dut7 (.clk(clk), .rst(rst), .bus(b7));

    typedef struct packed {
        logic [N_CH*AW-1:0]  v12;
        logic [N_CH*AW7-1:0] v7;
        logic [31:0]         due;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] wq[$];
    logic [7:0] img_m [2*BR];
    int         res12 [N_CH];
    int         res7  [N_CH];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int sat(int v, int w);
        int mx = (1 << (w - 1)) - 1;
        int mn = -(1 << (w - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    task automatic model_reset();
        wq.delete();
        for (int i = 0; i < NW; i++) wq.push_back(7'd0);
        for (int j = 0; j < 2 * BR; j++) img_m[j] = 8'd0;
        for (int c = 0; c < N_CH; c++) begin
            res12[c] = 0;
            res7[c]  = 0;
        end
    endtask

    task automatic model_apply(logic [2:0] op, logic [7:0] d, bit bank);
        case (op)
            3'd1: begin
                wq.push_front(d[6:0]);
                void'(wq.pop_back());
            end
            3'd2: for (int i = 0; i < BR; i++)
                      img_m[int'(bank)*BR + i] = {img_m[int'(bank)*BR + i][6:0], d[i]};
            3'd3: begin
                for (int j = 0; j < 2 * BR - 1; j++) img_m[j] = img_m[j+1];
                img_m[2*BR-1] = 8'd0;
            end
            3'd5: for (int c = 0; c < N_CH; c++) begin
                      res12[c] = 0;
                      res7[c]  = 0;
                  end
            default: ;
        endcase
    endtask

    // Whole-window match count per channel, turned into a bipolar dot product.
    task automatic model_compute(bit col, bit keep, output exp_t e);
        int         s, dotv;
        logic [6:0] w;
        e = '0;
        for (int c = 0; c < N_CH; c++) begin
            s = 0;
            for (int r = 0; r < K; r++) begin
                w = 7'(img_m[r] >> col);
                s += K - $countones(w ^ wq[c*K + r]);
            end
            dotv     = 2 * s - K * K;
            res12[c] = sat(dotv + (keep ? res12[c] : 0), AW);
            res7[c]  = sat(dotv + (keep ? res7[c] : 0), AW7);
            e.v12[c*AW +: AW]   = AW'(res12[c]);
            e.v7[c*AW7 +: AW7]  = AW7'(res7[c]);
        end
    endtask

    task automatic set_bus(bit s, bit v, logic [2:0] op, logic [7:0] d, bit bank, bit col, bit keep);
        b12.sel = s; b12.cmd_valid = v; b12.cmd = op; b12.data_in = d;
        b12.bank_sel = bank; b12.col_sel = col; b12.acc_keep = keep;
        b7.sel = s;  b7.cmd_valid = v;  b7.cmd = op;  b7.data_in = d;
        b7.bank_sel = bank;  b7.col_sel = col;  b7.acc_keep = keep;
    endtask

    task automatic bus_idle();
        set_bus(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_ready(bit r);
        b12.out_ready = r;
        b7.out_ready  = r;
    endtask

    task automatic do_cmd(logic [2:0] op, logic [7:0] d, bit bank, bit s);
        set_bus(s, 1'b1, op, d, bank, 1'b0, 1'b0);
        @(negedge clk);
        bus_idle();
        if (s && op != 3'd4) model_apply(op, d, bank);
    endtask

    task automatic do_compute(bit col, bit keep, int stall, bit expect_out);
        exp_t e;
        set_ready(stall == 0);
        set_bus(1'b1, 1'b1, 3'd4, 8'($urandom), 1'($urandom), col, keep);
        @(negedge clk);
        bus_idle();
        if (expect_out) begin
            model_compute(col, keep, e);
            e.due = 32'(cyc + K);
            exp_q.push_back(e);
        end
    endtask

    // Follows one computation to IDLE, injecting commands that must be ignored.
    task automatic wait_done(int stall);
        int n   = 1;
        int rel = -1;
        set_bus(1'b1, 1'b1, 3'd1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus_idle();
        while (n < 80 && !(b12.cmd_ready && b7.cmd_ready)) begin
            if (b12.out_valid) begin
                check("done_cmd_ready", b12.cmd_ready, 0);
                check("done_busy", b12.busy, 1);
                if (stall > 0) begin
                    stall--;
                    set_bus(1'b1, 1'b1, 3'd2, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
                end else begin
                    bus_idle();
                    set_ready(1'b1);
                    if (rel < 0) rel = n;
                end
            end
            @(negedge clk);
            n++;
        end
        bus_idle();
        set_ready(1'b1);
        check("idle_after_done", b12.cmd_ready & b7.cmd_ready, 1);
        check("handshake_exit", n, rel + 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_bpu_out", b12.bpu_out, 0);
        check("rst_bpu_out7", b7.bpu_out, 0);
        check("rst_out_valid", b12.out_valid, 0);
        check("rst_busy", b12.busy, 0);
        check("rst_cmd_ready", b12.cmd_ready, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_idle();
        set_ready(1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs();
    endtask

    task automatic load_ones_case();
        repeat (NW) do_cmd(3'd1, 8'h7F, 1'b0, 1'b1);
        repeat (K)  do_cmd(3'd2, 8'hFF, 1'b0, 1'b1);
    endtask

    // Monitor: pops the scoreboard on each rising out_valid and checks it while held.
    bit   prev_v = 1'b0;
    exp_t cur    = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (b12.out_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", b12.out_valid, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("latency", cyc, cur.due);
                    check("result_acc12", b12.bpu_out, cur.v12);
                    check("result_acc7", b7.bpu_out, cur.v7);
                    check("valid_acc7", b7.out_valid, 1);
                end
            end else if (b12.out_valid) begin
                check("hold_acc12", b12.bpu_out, cur.v12);
                check("hold_acc7", b7.bpu_out, cur.v7);
            end
            prev_v = b12.out_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int  op, stall;
        bit  s;
        bus_idle();
        set_ready(1'b1);
        do_reset();

        // All-ones weights and image: +49, then accumulate (98 / saturated 63), then overwrite.
        load_ones_case();
        do_compute(1'b0, 1'b0, 0, 1'b1); wait_done(0);
        do_compute(1'b0, 1'b1, 0, 1'b1); wait_done(0);
        do_compute(1'b0, 1'b0, 0, 1'b1); wait_done(0);

        // Zero weights against ones image: -49, then accumulate -98 / saturated -64.
        repeat (NW) do_cmd(3'd1, 8'h00, 1'b0, 1'b1);
        do_compute(1'b0, 1'b0, 0, 1'b1); wait_done(0);
        do_compute(1'b0, 1'b1, 0, 1'b1); wait_done(0);

        // Rows 0111_1111: column offset 0 gives 49, offset 1 gives 35.
        repeat (NW) do_cmd(3'd1, 8'h7F, 1'b0, 1'b1);
        do_cmd(3'd2, 8'h00, 1'b0, 1'b1);
        repeat (K) do_cmd(3'd2, 8'hFF, 1'b0, 1'b1);
        do_compute(1'b0, 1'b0, 0, 1'b1); wait_done(0);
        do_compute(1'b1, 1'b0, 0, 1'b1); wait_done(0);

        // Result held five cycles with ILOADs ignored; image proven unchanged afterwards.
        do_compute(1'b1, 1'b0, 5, 1'b1); wait_done(5);
        do_compute(1'b0, 1'b0, 0, 1'b1); wait_done(0);

        do_cmd(3'd5, 8'h00, 1'b0, 1'b1);
        check("clear_bpu_out", b12.bpu_out, 0);
        check("clear_bpu_out7", b7.bpu_out, 0);
        check("clear_out_valid", b12.out_valid, 0);
        check("clear_cmd_ready", b12.cmd_ready, 1);
        do_compute(1'b1, 1'b1, 0, 1'b1); wait_done(0);

        // Commands with sel low must not touch storage or results.
        do_cmd(3'd1, 8'h00, 1'b0, 1'b0);
        do_cmd(3'd5, 8'h00, 1'b0, 1'b0);
        do_cmd(3'd3, 8'h00, 1'b0, 1'b0);
        do_compute(1'b0, 1'b1, 0, 1'b1); wait_done(0);

        // Reset in the middle of CALC: no result may appear.
        do_compute(1'b0, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs();
        load_ones_case();
        do_compute(1'b0, 1'b0, 0, 1'b1); wait_done(0);

        for (int it = 0; it < 400; it++) begin
            op = int'($urandom_range(0, 7));
            s  = ($urandom_range(0, 3) != 0);
            if (op == 4 && s) begin
                stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                do_compute(1'($urandom), 1'($urandom), stall, 1'b1);
                wait_done(stall);
            end else begin
                do_cmd(3'(op), 8'($urandom), 1'($urandom), s);
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
